// File: rtl/multiply_xbar_pkg.sv
// Shared constants and width helpers for the multiply/crossbar/multiply pipe.
// Register addresses depend on the lane counts, so the map is expressed as
// helper functions evaluated at elaboration time by the top level.
package multiply_xbar_pkg;

   // Config map layout: coef_in, coef_out, route, then one ctrl register.
   localparam int unsigned COEF_IN_BASE = 0;

   // Ctrl register bit positions.
   localparam int unsigned CTRL_BYP1 = 0;
   localparam int unsigned CTRL_BYP2 = 1;
   localparam int unsigned CTRL_W    = 2;

   function automatic int unsigned selWidth(input int unsigned nIn);
      return (nIn <= 1) ? 1 : $clog2(nIn);
   endfunction

   function automatic int unsigned addrWidth(input int unsigned nIn, input int unsigned nOut);
      return $clog2(nIn + 2 * nOut + 1);
   endfunction

   function automatic int unsigned coefOutBase(input int unsigned nIn);
      return nIn;
   endfunction

   function automatic int unsigned routeBase(input int unsigned nIn, input int unsigned nOut);
      return nIn + nOut;
   endfunction

   function automatic int unsigned ctrlAddr(input int unsigned nIn, input int unsigned nOut);
      return nIn + 2 * nOut;
   endfunction

endpackage

// File: rtl/sat_mul.sv
// Combinational unsigned multiply with reduction back to DATA_W bits.
// ovf flags a nonzero upper half; SAT chooses clamp versus wrap.
module sat_mul #(
   parameter int unsigned DATA_W = 16,
   parameter bit          SAT    = 1'b1
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] product,
   output logic              ovf
);

   logic [2*DATA_W-1:0] full;

   // Full-width product, then clamp or truncate.
   always_comb begin
      full    = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
      ovf     = |full[2*DATA_W-1:DATA_W];
      product = (SAT && ovf) ? {DATA_W{1'b1}} : full[DATA_W-1:0];
   end

endmodule

// File: rtl/multiply_xbar_pipe.sv
// Two-stage streaming datapath: broadcast input scaled per input lane, routed
// through an N_IN->N_OUT crossbar, scaled per output lane. Both pipeline
// registers advance together under a single valid/ready enable, so a stall
// freezes everything and no beat is dropped or duplicated.
module multiply_xbar_pipe
   import multiply_xbar_pkg::*;
#(
   parameter int unsigned N_IN   = 4,
   parameter int unsigned N_OUT  = 4,
   parameter int unsigned DATA_W = 16,
   parameter bit          SAT    = 1'b1,
   localparam int unsigned SEL_W  = selWidth(N_IN),
   localparam int unsigned ADDR_W = addrWidth(N_IN, N_OUT)
) (
   input  logic                    Clk,
   input  logic                    Rst,
   input  logic [DATA_W-1:0]       dataIn,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [N_OUT*DATA_W-1:0] dataOut,
   output logic [N_OUT-1:0]        ovf_out,
   output logic                    out_valid,
   input  logic                    out_ready,
   input  logic                    cfg_we,
   input  logic [ADDR_W-1:0]       cfg_addr,
   input  logic [DATA_W-1:0]       cfg_data,
   output logic                    cfg_err,
   output logic                    busy
);

   localparam int unsigned COEF_OUT_BASE = coefOutBase(N_IN);
   localparam int unsigned ROUTE_BASE    = routeBase(N_IN, N_OUT);
   localparam int unsigned CTRL_ADDR     = ctrlAddr(N_IN, N_OUT);

   // Configuration state
   logic [DATA_W-1:0] coefIn  [N_IN];
   logic [DATA_W-1:0] coefOut [N_OUT];
   logic [SEL_W-1:0]  route   [N_OUT];
   logic [CTRL_W-1:0] ctrl;

   // Stage 1 combinational and registered values
   logic [DATA_W-1:0] mul1   [N_IN];
   logic [N_IN-1:0]   mulOvf1;
   logic [DATA_W-1:0] p1     [N_IN];
   logic [N_IN-1:0]   ovf1;
   logic [DATA_W-1:0] s1Data [N_IN];
   logic [N_IN-1:0]   s1Ovf;
   logic              s1Valid;

   // Crossbar and stage 2
   logic [DATA_W-1:0]       xData  [N_OUT];
   logic [N_OUT-1:0]        xOvf;
   logic [DATA_W-1:0]       mul2   [N_OUT];
   logic [N_OUT-1:0]        mulOvf2;
   logic [N_OUT*DATA_W-1:0] p2Flat;
   logic [N_OUT-1:0]        ovfNext;

   // Handshake and config decode
   logic advance;
   logic cfgAddrOk;
   logic cfgIsRoute;
   logic cfgRouteBad;
   logic cfgWrite;
   logic cfgReject;

   // Handshake: a single enable drives both pipeline registers.
   always_comb begin
      advance  = !out_valid || out_ready;
      in_ready = advance;
      busy     = s1Valid | out_valid;
   end

   // Config writes land only on an idle pipe with no beat entering.
   always_comb begin
      cfgAddrOk   = cfg_addr <= ADDR_W'(CTRL_ADDR);
      cfgIsRoute  = (cfg_addr >= ADDR_W'(ROUTE_BASE)) && (cfg_addr < ADDR_W'(CTRL_ADDR));
      cfgRouteBad = cfgIsRoute && (cfg_data >= DATA_W'(N_IN));
      cfgWrite    = cfg_we && !busy && !in_valid && cfgAddrOk && !cfgRouteBad;
      cfgReject   = cfg_we && !cfgWrite;
   end

   // Config register file with reset to identity coefficients and routing.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         for (int i = 0; i < int'(N_IN); i++) begin
            coefIn[i] <= DATA_W'(1);
         end
         for (int j = 0; j < int'(N_OUT); j++) begin
            coefOut[j] <= DATA_W'(1);
            route[j]   <= SEL_W'(j % int'(N_IN));
         end
         ctrl <= '0;
      end else if (cfgWrite) begin
         for (int i = 0; i < int'(N_IN); i++) begin
            if (cfg_addr == ADDR_W'(COEF_IN_BASE) + ADDR_W'(i)) begin
               coefIn[i] <= cfg_data;
            end
         end
         for (int j = 0; j < int'(N_OUT); j++) begin
            if (cfg_addr == ADDR_W'(COEF_OUT_BASE) + ADDR_W'(j)) begin
               coefOut[j] <= cfg_data;
            end
            if (cfg_addr == ADDR_W'(ROUTE_BASE) + ADDR_W'(j)) begin
               route[j] <= cfg_data[SEL_W-1:0];
            end
         end
         if (cfg_addr == ADDR_W'(CTRL_ADDR)) begin
            ctrl <= cfg_data[CTRL_W-1:0];
         end
      end
   end

   // Rejected writes report one cycle later.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         cfg_err <= 1'b0;
      end else begin
         cfg_err <= cfgReject;
      end
   end

   for (genvar i = 0; i < int'(N_IN); i++) begin : gStage1
      sat_mul #(
         .DATA_W (DATA_W),
         .SAT    (SAT)
      ) uMul (
         .a       (dataIn),
         .b       (coefIn[i]),
         .product (mul1[i]),
         .ovf     (mulOvf1[i])
      );
   end

   // Stage 1 result, or the raw input when bypassed.
   always_comb begin
      for (int i = 0; i < int'(N_IN); i++) begin
         p1[i]   = ctrl[CTRL_BYP1] ? dataIn : mul1[i];
         ovf1[i] = ctrl[CTRL_BYP1] ? 1'b0 : mulOvf1[i];
      end
   end

   // Crossbar: each output lane picks one s1 lane; fan-out is allowed.
   always_comb begin
      for (int j = 0; j < int'(N_OUT); j++) begin
         xData[j] = '0;
         xOvf[j]  = 1'b0;
         for (int i = 0; i < int'(N_IN); i++) begin
            if (route[j] == SEL_W'(i)) begin
               xData[j] = s1Data[i];
               xOvf[j]  = s1Ovf[i];
            end
         end
      end
   end

   for (genvar j = 0; j < int'(N_OUT); j++) begin : gStage2
      sat_mul #(
         .DATA_W (DATA_W),
         .SAT    (SAT)
      ) uMul (
         .a       (xData[j]),
         .b       (coefOut[j]),
         .product (mul2[j]),
         .ovf     (mulOvf2[j])
      );
   end

   // Stage 2 result; routed stage-1 overflow is carried into the lane flag.
   always_comb begin
      p2Flat  = '0;
      ovfNext = '0;
      for (int j = 0; j < int'(N_OUT); j++) begin
         if (ctrl[CTRL_BYP2]) begin
            p2Flat[j*DATA_W +: DATA_W] = xData[j];
            ovfNext[j]                 = xOvf[j];
         end else begin
            p2Flat[j*DATA_W +: DATA_W] = mul2[j];
            ovfNext[j]                 = xOvf[j] | mulOvf2[j];
         end
      end
   end

   // Pipeline registers; data loads only with a valid beat to limit toggling.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         s1Valid   <= 1'b0;
         s1Ovf     <= '0;
         out_valid <= 1'b0;
         dataOut   <= '0;
         ovf_out   <= '0;
         for (int i = 0; i < int'(N_IN); i++) begin
            s1Data[i] <= '0;
         end
      end else if (advance) begin
         s1Valid   <= in_valid;
         out_valid <= s1Valid;
         if (in_valid) begin
            s1Ovf <= ovf1;
            for (int i = 0; i < int'(N_IN); i++) begin
               s1Data[i] <= p1[i];
            end
         end
         if (s1Valid) begin
            dataOut <= p2Flat;
            ovf_out <= ovfNext;
         end
      end
   end

endmodule

// File: doc/multiply_xbar_pipe.md
# multiply_xbar_pipe

Parametrised, streaming two-stage multiply/crossbar/multiply datapath: every input beat is scaled by N_IN per-lane coefficients, routed through a configurable N_IN→N_OUT crossbar, then scaled by N_OUT per-lane coefficients. It has a valid/ready handshake with full-throughput backpressure, a register-mapped configuration port, optional saturation, and per-stage bypass. It sits between the chunk loader and the output mux in the compute fabric, and replaces hand-sequenced mStart/mReady/bufferRD control.

## Interface
- N_IN, 4 — input lanes (stage-1 multipliers), ≥1
- N_OUT, 4 — output lanes (stage-2 multipliers), ≥1
- DATA_W, 16 — unsigned operand/result width
- SAT, 1 — 1: clamp overflow to 2^DATA_W−1; 0: keep low DATA_W bits
- SEL_W, derived, max(1,clog2(N_IN)) — route-select width
- ADDR_W, derived, clog2(N_IN+2*N_OUT+1) — config address width
- Clk  in  1  clock, all logic rising-edge
- Rst  in  1  synchronous, active-high reset
- dataIn  in  DATA_W  input beat, broadcast to all stage-1 lanes
- in_valid  in  1  dataIn valid
- in_ready  out  1  beat accepted when in_valid && in_ready
- dataOut  out  N_OUT*DATA_W  lane j at [(j+1)*DATA_W-1 : j*DATA_W]
- ovf_out  out  N_OUT  per-lane overflow seen in stage 1 (routed lane) or stage 2
- out_valid  out  1  dataOut/ovf_out valid
- out_ready  in  1  consumer accepts when out_valid && out_ready
- cfg_we  in  1  config write strobe
- cfg_addr  in  ADDR_W  config register address
- cfg_data  in  DATA_W  config write data
- cfg_err  out  1  one-cycle pulse: write rejected
- busy  out  1  any beat in flight (s1_valid | out_valid)

## Operation
- Config map: 0..N_IN−1 coef_in[i]; N_IN..N_IN+N_OUT−1 coef_out[j]; N_IN+N_OUT..N_IN+2N_OUT−1 route[j] (low SEL_W bits); N_IN+2N_OUT ctrl (bit0 bypass stage 1, bit1 bypass stage 2).
- Config reset: coef_in=coef_out=1, route[j]=j mod N_IN, ctrl=0.
- Write accepted only when busy=0, in the same cycle that in_valid is low. Otherwise (busy=1, a simultaneous input accept, out-of-range address, or route value ≥N_IN) no state changes and cfg_err pulses the next cycle.
- Stage 1: p1[i] = dataIn*coef_in[i] (2·DATA_W-bit product), reduced to DATA_W per SAT; ovf1[i] = upper half nonzero. With bypass, p1[i]=dataIn and ovf1=0.
- Crossbar: x[j]=p1[route[j]], ovf carried along; fan-out (several j reading the same i) is legal.
- Stage 2: p2[j]=x[j]*coef_out[j], same width/SAT rules. ovf_out[j]=ovf1[route[j]] | ovf2[j].
- Two registered stages: s1 (p1, ovf1, s1_valid) and output (dataOut, ovf_out, out_valid).

## Timing
- advance = !out_valid || out_ready; in_ready = advance; s1 loads when advance, and s1_valid ← in_valid.
- Output register loads when advance: out_valid ← s1_valid.
- Latency: beat accepted at edge k → out_valid high after edge k+1; throughput 1 beat/cycle with out_ready held high.
- Stall: out_valid && !out_ready freezes both stages, and dataOut/ovf_out hold stable; no beat is dropped or duplicated.
- Bubble: in_valid low with advance high propagates a bubble; s1 data is don't-care but s1_valid=0.
- Reset (any cycle, including mid-stream): s1_valid=0, out_valid=0, dataOut=0, ovf_out=0, cfg_err=0, busy=0, config to reset values; in-flight beats discarded. in_ready=1 in the first cycle after reset.
- Config written at edge k applies to beats accepted at edge k+1 or later.

## Structure
- Package multiply_xbar_pkg holds the address-offset constants (COEF_IN_BASE, COEF_OUT_BASE, ROUTE_BASE, CTRL_ADDR), ctrl bit indices, and the SEL_W/ADDR_W derivation functions.
- Sub-module sat_mul (DATA_W, SAT): combinational multiply plus reduce, outputs product and ovf. Instantiated N_IN+N_OUT times.
- Top level holds the config regfile, s1 registers, crossbar mux, output registers and handshake.

## Test plan
- Defaults, DATA_W=16, N_IN=N_OUT=4: stream 1,2,3 with out_ready=1 → dataOut lanes equal to input, out_valid on cycles k+2..k+4, no gaps.
- coef_in[2]=3, route[0]=2, coef_out[0]=5; dataIn=7 → lane0=105, ovf_out[0]=0.
- SAT=1, coef_in[0]=0x100, dataIn=0x200 → lane0=0xFFFF, ovf_out[0]=1; SAT=0 build → lane0=0x0000, ovf_out[0]=1.
- out_ready low for 3 cycles mid-stream of 10 beats → in_ready low during the stall, dataOut held, all 10 beats delivered in order.
- cfg_we while busy=1, and cfg_we to route with value 5 (N_IN=4) → cfg_err pulses, config unchanged.
- Rst asserted with 2 beats in flight → next cycle out_valid=0, dataOut=0, coefficients=1; the following beat passes through unchanged.
